ising_sweep_ctrl: RTL and testbench

Sequencer for the 32x32 checkerboard Ising lattice. It drives the white and grey Spin enables, the lattice commit strobe, the random-generator seed load, and the periodic energy/magnetization measurement handshake. It runs a fixed number of Monte-Carlo sweeps per start request and sits between the testbench/host and the lattice datapath, replacing free-running enable toggling.

---
 rtl/ising_sweep_ctrl.sv | 132 +++++++++++++
 tb/tb_ising_sweep_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ising_sweep_ctrl.sv
// Sweep sequencer for the 32x32 checkerboard Ising lattice: seed load, colour phases, commits, measurement.
// Optional annealing temperature stepping is compiled in with `define ISING_ANNEAL_EN.
module ising_sweep_ctrl #(
   parameter int unsigned N_SWEEPS     = 1000,
   parameter int unsigned MEAS_EVERY   = 2,
   parameter int unsigned PHASE_CYCLES = 1,
   parameter int unsigned ANNEAL_EVERY = 100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   output logic        seed_ld,
   output logic        en_white,
   output logic        en_grey,
   output logic        lattice_we,
   output logic        meas_start,
   input  logic        meas_done,
   output logic        busy,
   output logic        done,
   output logic [15:0] sweep_cnt,
   output logic [3:0]  temp_idx
);

   typedef enum logic [2:0] {
      IDLE, SEED, WHITE, WCOMMIT, GREY, GCOMMIT, MEAS, DONE
   } state_t;

   localparam logic [15:0] N_SW     = 16'(N_SWEEPS);
   localparam bit          MEAS_ON  = (MEAS_EVERY != 0);
   localparam logic [15:0] MEAS_DIV = MEAS_ON ? 16'(MEAS_EVERY) : 16'd1;
   localparam logic [7:0]  PH_LAST  = 8'(PHASE_CYCLES - 1);

   state_t      state, next;
   logic [7:0]  phase_cnt;
   logic        meas_first;
   logic [15:0] n_next;
   logic        phase_last;

   assign n_next     = sweep_cnt + 16'd1;
   assign phase_last = (phase_cnt == PH_LAST);

   always_comb begin
      next       = state;
      seed_ld    = 1'b0;
      en_white   = 1'b0;
      en_grey    = 1'b0;
      lattice_we = 1'b0;
      meas_start = 1'b0;
      busy       = (state != IDLE);
      done       = 1'b0;
      case (state)
         IDLE:    if (start && !abort) next = SEED;
         SEED: begin
            seed_ld = 1'b1;
            next    = (N_SW == 16'd0) ? DONE : WHITE;
         end
         WHITE: begin
            en_white = 1'b1;
            if (phase_last) next = WCOMMIT;
         end
         WCOMMIT: begin
            en_white   = 1'b1;
            lattice_we = 1'b1;
            next       = GREY;
         end
         GREY: begin
            en_grey = 1'b1;
            if (phase_last) next = GCOMMIT;
         end
         GCOMMIT: begin
            en_grey    = 1'b1;
            lattice_we = 1'b1;
            if (MEAS_ON && ((n_next % MEAS_DIV) == 16'd0)) next = MEAS;
            else if (n_next == N_SW)                       next = DONE;
            else                                           next = WHITE;
         end
         MEAS: begin
            // meas_done is only honoured after the pulse cycle, so a stale level cannot end the wait early
            meas_start = meas_first;
            if (!meas_first && meas_done) next = (sweep_cnt == N_SW) ? DONE : WHITE;
         end
         DONE: begin
            done = 1'b1;
            next = IDLE;
         end
         default: next = IDLE;
      endcase
      if (abort && state != IDLE) next = IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         phase_cnt  <= 8'd0;
         meas_first <= 1'b0;
         sweep_cnt  <= 16'd0;
      end else begin
         state      <= next;
         meas_first <= (next == MEAS) && (state != MEAS);
         if ((state == WHITE || state == GREY) && next == state)
            phase_cnt <= phase_cnt + 8'd1;
         else
            phase_cnt <= 8'd0;
         if (state == IDLE && next == SEED)
            sweep_cnt <= 16'd0;
         else if (state == GCOMMIT && !abort)
            sweep_cnt <= n_next;
      end
   end

`ifdef ISING_ANNEAL_EN
   localparam logic [15:0] ANN_DIV = 16'(ANNEAL_EVERY);
   logic [3:0] temp_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         temp_q <= 4'd0;
      else if (state == IDLE && next == SEED)
         temp_q <= 4'd0;
      else if (state == GCOMMIT && !abort && (n_next % ANN_DIV) == 16'd0 && temp_q != 4'd15)
         temp_q <= temp_q + 4'd1;
   end

   assign temp_idx = temp_q;
`else
   logic [15:0] unused_anneal;
   assign unused_anneal = 16'(ANNEAL_EVERY);
   assign temp_idx      = 4'd0;
`endif

endmodule

// File: tb/tb_ising_sweep_ctrl.sv
// Bench for ising_sweep_ctrl: four differently configured instances driven against an event-schedule model.
module tb_ising_sweep_ctrl;

   localparam int NI = 4;
   localparam int NS [NI] = '{3, 4, 0, 40};
   localparam int ME [NI] = '{0, 2, 0, 0};
   localparam int PC [NI] = '{1, 2, 1, 1};
   localparam int AE [NI] = '{100, 3, 100, 10};
`ifdef ISING_ANNEAL_EN
   localparam bit ANNEAL = 1'b1;
`else
   localparam bit ANNEAL = 1'b0;
`endif

   // flag order: seed, white, grey, we, meas_start, busy, done
   localparam bit [6:0] F_IDLE = 7'b0000000;
   localparam bit [6:0] F_SEED = 7'b1000010;
   localparam bit [6:0] F_W    = 7'b0100010;
   localparam bit [6:0] F_WC   = 7'b0101010;
   localparam bit [6:0] F_G    = 7'b0010010;
   localparam bit [6:0] F_GC   = 7'b0011010;
   localparam bit [6:0] F_MS   = 7'b0000110;
   localparam bit [6:0] F_MW   = 7'b0000010;
   localparam bit [6:0] F_DN   = 7'b0000011;

   typedef struct packed {
      logic [6:0]  f;
      logic [15:0] cnt;
      logic [3:0]  temp;
   } obs_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_i [NI];
   logic        abort_i [NI];
   logic        md_i    [NI];
   logic        seed_o  [NI];
   logic        w_o     [NI];
   logic        g_o     [NI];
   logic        we_o    [NI];
   logic        ms_o    [NI];
   logic        busy_o  [NI];
   logic        done_o  [NI];
   logic [15:0] cnt_o   [NI];
   logic [3:0]  temp_o  [NI];

   int   n_checks = 0;
   int   n_fail   = 0;
   obs_t expq [$];
   int   mdq  [$];
   int   m_cnt, m_temp;
   int   prev_cnt  [NI];
   int   prev_temp [NI];
   int   obs_done_cyc, obs_ms;

   always #5 clk = ~clk;

   for (genvar k = 0; k < NI; k++) begin : g_dut
      ising_sweep_ctrl #(
         .N_SWEEPS(NS[k]), .MEAS_EVERY(ME[k]), .PHASE_CYCLES(PC[k]), .ANNEAL_EVERY(AE[k])
      ) u_dut (
         .clk(clk), .reset(reset), .start(start_i[k]), .abort(abort_i[k]),
         .seed_ld(seed_o[k]), .en_white(w_o[k]), .en_grey(g_o[k]), .lattice_we(we_o[k]),
         .meas_start(ms_o[k]), .meas_done(md_i[k]), .busy(busy_o[k]), .done(done_o[k]),
         .sweep_cnt(cnt_o[k]), .temp_idx(temp_o[k])
      );
   end

   function automatic obs_t sample(input int id);
      sample = {seed_o[id], w_o[id], g_o[id], we_o[id], ms_o[id], busy_o[id], done_o[id],
                cnt_o[id], temp_o[id]};
   endfunction

   task automatic push(input bit [6:0] f, input int md);
      obs_t e;
      e.f    = f;
      e.cnt  = 16'(m_cnt);
      e.temp = 4'(m_temp);
      expq.push_back(e);
      mdq.push_back(md);
   endtask

   // Expected per-cycle schedule; md: 0/1 = meas_done value required, 2 = free (driven random)
   task automatic build(input int id, input int lat);
      int k;
      expq.delete();
      mdq.delete();
      m_cnt  = prev_cnt[id];
      m_temp = prev_temp[id];
      push(F_IDLE, 2);
      m_cnt  = 0;
      m_temp = 0;
      push(F_SEED, 2);
      for (int s = 1; s <= NS[id]; s++) begin
         repeat (PC[id]) push(F_W, 2);
         push(F_WC, 2);
         repeat (PC[id]) push(F_G, 2);
         push(F_GC, 2);
         m_cnt = s;
         if (ANNEAL && (s % AE[id]) == 0 && m_temp < 15) m_temp++;
         if (ME[id] != 0 && (s % ME[id]) == 0) begin
            k = (lat > 0) ? lat : int'($urandom_range(1, 4));
            push(F_MS, 2);
            for (int j = 1; j < k; j++) push(F_MW, 0);
            push(F_MW, 1);
         end
      end
      push(F_DN, 2);
   endtask

   // abort_at: -1 none, 0 random cycle, >0 that cycle index
   task automatic run(input int id, input int abort_at, input int lat, input string name);
      int   a;
      obs_t got, hold;
      build(id, lat);
      a = abort_at;
      if (abort_at == 0) a = $urandom_range(1, expq.size() - 1);
      if (a > 0) begin
         while (expq.size() > a + 1) begin
            void'(expq.pop_back());
            void'(mdq.pop_back());
         end
         hold   = expq[a];
         m_cnt  = int'(hold.cnt);
         m_temp = int'(hold.temp);
         push(F_IDLE, 2);
      end
      obs_done_cyc = -1;
      obs_ms       = 0;
      for (int i = 0; i < expq.size(); i++) begin
         @(negedge clk);
         got = sample(id);
         n_checks++;
         if (got !== expq[i]) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got flags=%b cnt=%0d temp=%0d, expected flags=%b cnt=%0d temp=%0d",
                     name, i, got.f, got.cnt, got.temp, expq[i].f, expq[i].cnt, expq[i].temp);
         end
         n_checks++;
         if (w_o[id] && g_o[id]) begin
            n_fail++;
            $display("FAIL %s overlap cycle %0d: en_white=%b en_grey=%b, expected not both 1",
                     name, i, w_o[id], g_o[id]);
         end
         if (done_o[id] === 1'b1) obs_done_cyc = i;
         if (ms_o[id] === 1'b1) obs_ms++;
         start_i[id] = (i == 0) ? 1'b1 : (expq[i].f[1] ? 1'($urandom_range(0, 1)) : 1'b0);
         abort_i[id] = (i == a);
         md_i[id]    = (mdq[i] == 2) ? 1'($urandom_range(0, 1)) : 1'(mdq[i]);
      end
      start_i[id] = 1'b0;
      abort_i[id] = 1'b0;
      md_i[id]    = 1'b0;
      prev_cnt[id]  = int'(expq[expq.size() - 1].cnt);
      prev_temp[id] = int'(expq[expq.size() - 1].temp);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int k = 0; k < NI; k++) begin
         start_i[k]   = 1'b0;
         abort_i[k]   = 1'b0;
         md_i[k]      = 1'b0;
         prev_cnt[k]  = 0;
         prev_temp[k] = 0;
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (sample(k) !== obs_t'(0)) begin
               n_fail++;
               $display("FAIL reset_idle inst %0d: got %h, expected 0", k, sample(k));
            end
         end
      end
   endtask

   task automatic test_basic();
      run(0, -1, 0, "basic");
      n_checks++;
      if (obs_done_cyc != 14) begin
         n_fail++;
         $display("FAIL basic_done_cycle: got %0d, expected 14", obs_done_cyc);
      end
      @(negedge clk);
      n_checks++;
      if (cnt_o[0] !== 16'd3 || busy_o[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_hold: got cnt=%0d busy=%b, expected cnt=3 busy=0", cnt_o[0], busy_o[0]);
      end
   endtask

   task automatic test_meas();
      run(1, -1, 3, "meas_lat3");
      n_checks++;
      if (obs_ms != 2) begin
         n_fail++;
         $display("FAIL meas_pulses: got %0d, expected 2", obs_ms);
      end
      for (int r = 0; r < 3; r++) run(1, -1, 0, "meas_rand");
   endtask

   task automatic test_zero_sweeps();
      run(2, -1, 0, "zero");
      n_checks++;
      if (obs_done_cyc != 2) begin
         n_fail++;
         $display("FAIL zero_done_cycle: got %0d, expected 2", obs_done_cyc);
      end
   endtask

   task automatic test_anneal();
      run(3, -1, 0, "anneal");
      n_checks++;
      if (temp_o[3] !== (ANNEAL ? 4'd4 : 4'd0)) begin
         n_fail++;
         $display("FAIL anneal_final: got %0d, expected %0d", temp_o[3], ANNEAL ? 4 : 0);
      end
   endtask

   task automatic test_abort();
      run(0, 8, 0, "abort_grey2");
      n_checks++;
      if (obs_done_cyc != -1 || cnt_o[0] !== 16'd1) begin
         n_fail++;
         $display("FAIL abort_state: got done_cycle=%0d cnt=%0d, expected none and 1",
                  obs_done_cyc, cnt_o[0]);
      end
      run(0, -1, 0, "abort_rerun");
      for (int r = 0; r < 6; r++) run(1, 0, 0, "abort_rand");
   endtask

   task automatic test_back_to_back();
      run(1, -1, 0, "b2b_first");
      run(1, -1, 0, "b2b_second");
   endtask

   task automatic test_abort_start_idle();
      @(negedge clk);
      start_i[0] = 1'b1;
      abort_i[0] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy_o[0] !== 1'b0 || seed_o[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_start_idle: got busy=%b seed_ld=%b, expected 0 0", busy_o[0], seed_o[0]);
      end
      start_i[0] = 1'b0;
      abort_i[0] = 1'b0;
   endtask

   task automatic test_reset_midrun();
      @(negedge clk);
      start_i[0] = 1'b1;
      @(negedge clk);
      start_i[0] = 1'b0;
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      n_checks++;
      if (sample(0) !== obs_t'(0)) begin
         n_fail++;
         $display("FAIL reset_midrun: got %h, expected 0 before next edge", sample(0));
      end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < NI; k++) begin
         prev_cnt[k]  = 0;
         prev_temp[k] = 0;
      end
      run(0, -1, 0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_meas();
      test_zero_sweeps();
      test_anneal();
      test_abort();
      test_back_to_back();
      test_abort_start_idle();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
